uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
// Parametrised UART receiver for the remote-comm link. Handles 5-9 data bits,
// optional even/odd parity and stop-bit checking, with false-start rejection and
// error flags (parity, framing, overrun). Sits between the RX pad and the command
// parser; the consumer sees a byte plus a rdy/clr_rdy handshake.
// PARAMETERS
// CLK_DIV     2604  clk cycles per bit (50 MHz / 19200); legal range 8..4095
// DATA_BITS   8     data bits per frame, 5..9, LSB first
// PARITY_EN   0     1 = one parity bit follows the data
// PARITY_ODD  0     parity sense when PARITY_EN=1: 0 = even, 1 = odd
// PORTS
// clk         in   1          system clock
// rst_n       in   1          reset, asynchronous, active-low
// RX          in   1          serial input, asynchronous, idles high
// clr_rdy     in   1          consumer acknowledge; clears rdy and all error flags
// rx_data     out  DATA_BITS  last received data word
// rdy         out  1          word valid, held until clr_rdy or the next start bit
// parity_err  out  1          parity mismatch on the word in rx_data
// frame_err   out  1          stop bit sampled low on the word in rx_data
// overrun     out  1          a word completed while rdy was still set
// BEHAVIOUR
// - Reset: rx_data=0, rdy=0, all error flags=0, state=IDLE, both sync flops=1.
// - RX passes through a 2-flop synchroniser (rx_s). All logic uses rx_s only.
// - Baud counter: down-counter, ceil(log2(CLK_DIV)) bits. It is loaded with
//   CLK_DIV/2-1 on start detect and with CLK_DIV-1 at each sample point. A sample
//   point is the cycle in which the counter reaches 0.
// - Bit counter: counts data bits 0..DATA_BITS-1.
// - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
//   - IDLE -> START when rx_s==0. Load the counter with the half-bit value.
//   - START at sample: rx_s==1 means a false start; go to IDLE with no flag change.
//     Otherwise go to DATA.
//   - DATA: at each sample, shift rx_s into the MSB of the DATA_BITS shift register.
//     After DATA_BITS samples, go to PARITY if PARITY_EN=1, else go to STOP.
//   - PARITY: sample one bit, then go to STOP.
//   - STOP at sample: perform the completion actions below. Go to IDLE if rx_s==1,
//     else go to BREAK.
//   - BREAK: wait for rx_s==1, then go to IDLE. A held-low line gives exactly one
//     framed word.
// - Completion actions, applied in the cycle after the stop sample:
//   - rx_data <= shift register; rdy <= 1.
//   - frame_err <= ~stop bit.
//   - parity_err <= (^data ^ parity bit) != PARITY_ODD; forced to 0 when PARITY_EN=0.
//   - overrun <= rdy (the value before this update).
// - rdy and error flags clear on clr_rdy or on a start detect in IDLE.
//   If a clear and a completion land in the same cycle, the completion wins.
// - Timing: the stop-bit sample falls CLK_DIV/2 + (1+DATA_BITS+PARITY_EN)*CLK_DIV
//   cycles after start detect. rdy rises 1 cycle later; rx_data is valid in the
//   same cycle rdy rises.
// - rst_n asserted mid-frame aborts the frame at once. No partial word is exposed.
// TESTING (CLK_DIV=16 unless noted)
// - 8N1, send 0xA5 -> rdy rises 8+9*16+1 cycles after start detect; rx_data=0xA5;
//   all error flags 0.
// - 0.25-bit low glitch (4 cycles) on an idle line -> FSM returns to IDLE; rdy stays
//   0 and no flag changes.
// - PARITY_EN=1, PARITY_ODD=1: send 0x03 with parity bit 1 -> parity_err=0.
//   Same data with parity bit 0 -> parity_err=1 and rdy=1.
// - Send 0x3C with stop bit low, then hold RX low 5 bit-times -> one word, frame_err=1;
//   no second rdy until RX returns high and a new start bit arrives.
// - Two back-to-back frames 0x11, 0x22 with no clr_rdy -> rx_data=0x22, overrun=1.
//   Then clr_rdy -> rdy=0 and overrun=0 on the next cycle.
// - DATA_BITS=9 (rx_data=0x1F0) and DATA_BITS=5 (rx_data=0x15) frames received
//   correctly. Assert rst_n mid-DATA -> all outputs 0 and the next frame is received
//   cleanly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// ----------------------------------------------------------------------------
// uart_rx_cfg
// Parametrised UART receiver for the remote-comm link. It sits between the RX
// pad and the command parser. It accepts 5-9 data bits sent LSB first, with an
// optional even or odd parity bit and a stop-bit check. A start bit that has
// gone high again by mid-bit is rejected as a false start. The receiver
// reports parity, framing and overrun errors.
//
// Parameters
//   CLK_DIV     clk cycles per bit (8..4095)
//   DATA_BITS   data bits per frame (5..9)
//   PARITY_EN   1 = one parity bit follows the data
//   PARITY_ODD  parity sense when enabled: 0 = even, 1 = odd
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   RX          serial input, asynchronous, idles high
//   clr_rdy     consumer acknowledge; clears rdy and every error flag
//   rx_data     last received data word
//   rdy         word valid; held until clr_rdy or the next start bit
//   parity_err  parity mismatch on the word in rx_data
//   frame_err   stop bit was sampled low on the word in rx_data
//   overrun     a word completed before the previous one was acknowledged
// ----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             PAR_ON    = (PARITY_EN != 0);
  localparam logic             ODD_SENSE = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t                 state;
  state_t                 next_state;

  logic                   rx_meta;
  logic                   rx_s;
  logic [CNT_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   unread;

  logic                   sample;
  logic                   start_det;
  logic                   load_full;
  logic                   shift_en;
  logic                   par_cap;
  logic                   complete;

  // Two-flop synchroniser. Both flops reset high, so a reset with RX idle
  // cannot look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // A sample point is any cycle in which the baud counter sits at zero.
  // Only the bit-timing states act on it.
  assign sample = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the per-cycle datapath strobes.
  always_comb begin
    next_state = state;
    start_det  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          start_det  = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s) begin
            next_state = IDLE;
          end else begin
            load_full  = 1'b1;
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            next_state = PAR_ON ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          par_cap    = 1'b1;
          load_full  = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          complete   = 1'b1;
          next_state = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        // A line held low stays here, so it yields only one framed word.
        if (rx_s) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Baud down-counter. A half-bit load at start detect places every later
  // sample at the middle of its bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if (start_det) begin
      baud_cnt <= HALF_LOAD;
    end else if (load_full) begin
      baud_cnt <= FULL_LOAD;
    end else if (baud_cnt != '0) begin
      baud_cnt <= baud_cnt - 1'b1;
    end
  end

  // Data bit counter, plus a shift register that fills from the MSB end.
  // After DATA_BITS shifts, the first (LSB) bit sits at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
      if (par_cap) begin
        par_bit <= rx_s;
      end
    end
  end

  // Consumer-facing registers.
  // rdy drops at the next start bit so a stale word is never shown as fresh.
  // That alone would hide a word the consumer never acknowledged. The internal
  // 'unread' flag therefore remembers an unacknowledged word until clr_rdy,
  // and overrun reports that flag when the next word lands.
  // A completion takes priority over a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      unread     <= 1'b0;
    end else if (complete) begin
      rx_data    <= shreg;
      rdy        <= 1'b1;
      frame_err  <= ~rx_s;
      parity_err <= PAR_ON && ((^shreg ^ par_bit) != ODD_SENSE);
      overrun    <= unread;
      unread     <= 1'b1;
    end else if (clr_rdy) begin
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      unread     <= 1'b0;
    end else if (start_det) begin
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
